// File: rtl/alu_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencer: ALU op encodings, controller state
// encoding and the default datapath width.
// Optional build macro used elsewhere in this slice: ALU_SEQ_FLAGS_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_W_DEF = 4;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_NOT = 3'b010,
      ALU_AND = 3'b011,
      ALU_OR  = 3'b100,
      ALU_XOR = 3'b101,
      ALU_RSV = 3'b110,
      ALU_EQ  = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_if
// Bundles the two requester channels, the ALU drive/result signals and the
// response channel of the ALU sequencer.
//   slave  : controller side (alu_seq_ctrl)
//   master : environment side (requesters, ALU, response consumer)
// Signals: reqN_valid/ready/a/b/op, alu_a/b/op, alu_res, rsp_valid/ready/id/
//          data, busy, and rsp_zero when ALU_SEQ_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
interface alu_seq_ctrl_if
   import alu_pkg::*;
#(
   parameter int W = ALU_W_DEF
);
   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic [2:0]   req0_op;

   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic [2:0]   req1_op;

   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [2:0]   alu_op;
   logic [W-1:0] alu_res;

   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_data;
`ifdef ALU_SEQ_FLAGS_EN
   logic         rsp_zero;
`endif
   logic         busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output alu_a, alu_b, alu_op,
      input  alu_res,
      output rsp_valid, rsp_id, rsp_data,
`ifdef ALU_SEQ_FLAGS_EN
      output rsp_zero,
`endif
      input  rsp_ready,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  alu_a, alu_b, alu_op,
      output alu_res,
      input  rsp_valid, rsp_id, rsp_data,
`ifdef ALU_SEQ_FLAGS_EN
      input  rsp_zero,
`endif
      output rsp_ready,
      input  busy
   );

endinterface

// File: rtl/alu_seq_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational 2-way round-robin arbiter. The history bit is held by the
// caller and passed in as i_last_grant.
//   i_valid[1:0]  request lines (bit N = requester N)
//   i_last_grant  requester granted most recently
//   i_en          arbitration enable; no grant when low
//   o_grant[1:0]  one-hot grant
//   o_grant_id    index of the granted requester (0 when nothing granted)
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] i_valid,
   input  logic       i_last_grant,
   input  logic       i_en,
   output logic [1:0] o_grant,
   output logic       o_grant_id
);

   always_comb begin
      o_grant    = 2'b00;
      o_grant_id = 1'b0;
      if (i_en) begin
         case (i_valid)
            2'b01: begin
               o_grant    = 2'b01;
               o_grant_id = 1'b0;
            end
            2'b10: begin
               o_grant    = 2'b10;
               o_grant_id = 1'b1;
            end
            2'b11: begin
               // Contention: whoever did not win last time goes now.
               o_grant_id = ~i_last_grant;
               o_grant    = i_last_grant ? 2'b01 : 2'b10;
            end
            default: begin
               o_grant    = 2'b00;
               o_grant_id = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Sequencer/arbiter in front of a shared combinational ALU. Accepts one
// operand/op transaction at a time from two requesters (round-robin), drives
// the ALU from registers, waits ALU_LAT cycles, samples the result and returns
// it on a valid/ready response channel tagged with the requester ID.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_seq_ctrl_if.slave (requesters, ALU drive/result, response, busy)
// Parameters: W (datapath width), ALU_LAT (settle cycles, 1..15).
// Build macro ALU_SEQ_FLAGS_EN adds the registered rsp_zero flag.
// -----------------------------------------------------------------------------
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int W       = ALU_W_DEF,
   parameter int ALU_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   alu_seq_ctrl_if.slave bus
);

   if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
      $error("alu_seq_ctrl: ALU_LAT must be within 1..15");
   end

   localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT);

   state_e       r_state;
   state_e       w_state_nxt;
   logic         r_last_grant;
   logic [3:0]   r_cnt;
   logic         r_id;
   logic [W-1:0] r_alu_a;
   logic [W-1:0] r_alu_b;
   logic [2:0]   r_alu_op;
   logic         r_rsp_valid;
   logic         r_rsp_id;
   logic [W-1:0] r_rsp_data;
`ifdef ALU_SEQ_FLAGS_EN
   logic         r_rsp_zero;
`endif

   logic [1:0]   w_grant;
   logic         w_grant_id;
   logic         w_arb_en;
   logic         w_accept;
   logic         w_busy;
   logic         w_sample;
   logic [W-1:0] w_req_a;
   logic [W-1:0] w_req_b;
   logic [2:0]   w_req_op;

   rr_arb2 u_arb (
      .i_valid      ({bus.req1_valid, bus.req0_valid}),
      .i_last_grant (r_last_grant),
      .i_en         (w_arb_en),
      .o_grant      (w_grant),
      .o_grant_id   (w_grant_id)
   );

   // A grant is only ever issued to a valid requester, so any grant is an accept.
   assign w_accept = |w_grant;
   assign w_sample = (r_state == S_ISSUE) && (r_cnt == 4'd1);

   assign w_req_a  = w_grant_id ? bus.req1_a  : bus.req0_a;
   assign w_req_b  = w_grant_id ? bus.req1_b  : bus.req0_b;
   assign w_req_op = w_grant_id ? bus.req1_op : bus.req0_op;

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)      w_state_nxt = S_ISSUE;
         S_ISSUE: if (r_cnt == 4'd1) w_state_nxt = S_DONE;
         S_DONE:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
         default:                    w_state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_arb_en = (r_state == S_IDLE);
      w_busy   = (r_state != S_IDLE);
   end

   // Operand/op capture, settle counter, arbitration history and response.
   // ALU drive registers keep their value until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= 1'b1;
         r_cnt        <= 4'd0;
         r_id         <= 1'b0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= 3'b000;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_data   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
         r_rsp_zero   <= 1'b0;
`endif
      end else begin
         if (r_state == S_IDLE && w_accept) begin
            r_alu_a      <= w_req_a;
            r_alu_b      <= w_req_b;
            r_alu_op     <= w_req_op;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_cnt        <= CNT_LOAD;
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_sample) begin
            r_rsp_data  <= bus.alu_res;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            r_rsp_zero  <= (bus.alu_res == '0);
`endif
         end
         if (r_state == S_DONE && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign bus.req0_ready = w_grant[0];
   assign bus.req1_ready = w_grant[1];
   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign bus.alu_op     = r_alu_op;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_id     = r_rsp_id;
   assign bus.rsp_data   = r_rsp_data;
`ifdef ALU_SEQ_FLAGS_EN
   assign bus.rsp_zero   = r_rsp_zero;
`endif
   assign bus.busy       = w_busy;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Bench for alu_seq_ctrl: one instance with ALU_LAT=1 for the main traffic and
// one with ALU_LAT=4 for the mid-transaction reset case. A behavioural ALU
// closes the loop; expected responses are queued by the stimulus and checked
// by monitors on each response handshake.
// Honours ALU_SEQ_FLAGS_EN (rsp_zero checking).
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;
   import alu_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_seq_ctrl_if #(.W(W)) bus1 ();
   alu_seq_ctrl_if #(.W(W)) bus4 ();

   alu_seq_ctrl #(.W(W), .ALU_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   alu_seq_ctrl #(.W(W), .ALU_LAT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

   function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] op);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_NOT: return ~a;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_EQ:  return (a == b) ? 4'd1 : 4'd0;
         default: return 4'd0;
      endcase
   endfunction

   assign bus1.alu_res = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_op);
   assign bus4.alu_res = alu_model(bus4.alu_a, bus4.alu_b, bus4.alu_op);

   typedef struct packed {
      logic         id;
      logic [W-1:0] data;
      logic         zero;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name, input string why);
      checks++;
      errors++;
      $display("FAIL %s: %s (t=%0t)", name, why, $time);
   endtask

   task automatic push1(input logic id, input logic [W-1:0] data);
      exp_t e;
      e.id = id; e.data = data; e.zero = (data == 4'd0);
      q1.push_back(e);
   endtask

   task automatic push4(input logic id, input logic [W-1:0] data);
      exp_t e;
      e.id = id; e.data = data; e.zero = (data == 4'd0);
      q4.push_back(e);
   endtask

   // Present a transaction and hold it until the accept edge; returns 1 time
   // unit after that edge.
   task automatic send1(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op);
      bit done = 1'b0;
      if (id) begin
         bus1.req1_a = a; bus1.req1_b = b; bus1.req1_op = op; bus1.req1_valid = 1'b1;
      end else begin
         bus1.req0_a = a; bus1.req0_b = b; bus1.req0_op = op; bus1.req0_valid = 1'b1;
      end
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if ((id ? bus1.req1_ready : bus1.req0_ready) === 1'b1) done = 1'b1;
      end
      if (!done) fail("send1_timeout", "ready never asserted");
      else begin @(posedge clk); #1; end
      if (id) bus1.req1_valid = 1'b0; else bus1.req0_valid = 1'b0;
   endtask

   task automatic send4(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op);
      bit done = 1'b0;
      if (id) begin
         bus4.req1_a = a; bus4.req1_b = b; bus4.req1_op = op; bus4.req1_valid = 1'b1;
      end else begin
         bus4.req0_a = a; bus4.req0_b = b; bus4.req0_op = op; bus4.req0_valid = 1'b1;
      end
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if ((id ? bus4.req1_ready : bus4.req0_ready) === 1'b1) done = 1'b1;
      end
      if (!done) fail("send4_timeout", "ready never asserted");
      else begin @(posedge clk); #1; end
      if (id) bus4.req1_valid = 1'b0; else bus4.req0_valid = 1'b0;
   endtask

   task automatic wait_idle1();
      bit done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (!bus1.busy && !bus1.rsp_valid && !bus1.req0_valid && !bus1.req1_valid) done = 1'b1;
      end
      if (!done) fail("idle_timeout", "controller never returned to idle");
      @(posedge clk); #1;
   endtask

   // Response monitors: every handshake must match the next queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus1.rsp_valid && bus1.rsp_ready) begin
            if (q1.size() == 0) fail("rsp1_unexpected", "response with nothing outstanding");
            else begin
               e = q1.pop_front();
               chk("rsp1_id", bus1.rsp_id, e.id);
               chk("rsp1_data", bus1.rsp_data, e.data);
`ifdef ALU_SEQ_FLAGS_EN
               chk("rsp1_zero", bus1.rsp_zero, e.zero);
`endif
            end
         end
         if (bus1.busy) chk("ready_while_busy", {bus1.req1_ready, bus1.req0_ready}, 0);
         if (bus4.rsp_valid && bus4.rsp_ready) begin
            if (q4.size() == 0) fail("rsp4_unexpected", "response with nothing outstanding");
            else begin
               e = q4.pop_front();
               chk("rsp4_id", bus4.rsp_id, e.id);
               chk("rsp4_data", bus4.rsp_data, e.data);
`ifdef ALU_SEQ_FLAGS_EN
               chk("rsp4_zero", bus4.rsp_zero, e.zero);
`endif
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_op = 0;
      bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_op = 0;
      bus4.req0_valid = 0; bus4.req0_a = 0; bus4.req0_b = 0; bus4.req0_op = 0;
      bus4.req1_valid = 0; bus4.req1_a = 0; bus4.req1_b = 0; bus4.req1_op = 0;
      bus1.rsp_ready = 1'b1;
      bus4.rsp_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_alu_a", bus1.alu_a, 0);
      chk("rst_alu_b", bus1.alu_b, 0);
      chk("rst_alu_op", bus1.alu_op, 0);
      chk("rst_rsp_valid", bus1.rsp_valid, 0);
      chk("rst_rsp_data", bus1.rsp_data, 0);
      chk("rst_rsp_id", bus1.rsp_id, 0);
      chk("rst_busy", bus1.busy, 0);
      @(posedge clk); #1;

      // Contention from reset: req0 first (9-4=5), then req1 (6==6 -> 1)
      push1(1'b0, 4'd5);
      push1(1'b1, 4'd1);
      fork
         send1(1'b0, 4'd9, 4'd4, ALU_SUB);
         send1(1'b1, 4'd6, 4'd6, ALU_EQ);
      join
      wait_idle1();

      // Fairness: both requesters continuously valid -> ids 0,1,0,1,0,1
      push1(1'b0, 4'd3); push1(1'b1, 4'd7);
      push1(1'b0, 4'd4); push1(1'b1, 4'd6);
      push1(1'b0, 4'd5); push1(1'b1, 4'd5);
      fork
         begin
            send1(1'b0, 4'd1, 4'd2, ALU_ADD);
            send1(1'b0, 4'd2, 4'd2, ALU_ADD);
            send1(1'b0, 4'd3, 4'd2, ALU_ADD);
         end
         begin
            send1(1'b1, 4'd8, 4'd1, ALU_SUB);
            send1(1'b1, 4'd8, 4'd2, ALU_SUB);
            send1(1'b1, 4'd8, 4'd3, ALU_SUB);
         end
      join
      wait_idle1();

      // Single request timing with ALU_LAT=1: 3+5=8
      push1(1'b0, 4'd8);
      send1(1'b0, 4'd3, 4'd5, ALU_ADD);
      chk("single_alu_a", bus1.alu_a, 3);
      chk("single_alu_b", bus1.alu_b, 5);
      chk("single_alu_op", bus1.alu_op, 0);
      chk("single_busy", bus1.busy, 1);
      chk("single_valid_early", bus1.rsp_valid, 0);
      @(posedge clk); #1;
      chk("single_valid_t2", bus1.rsp_valid, 1);
      chk("single_id_t2", bus1.rsp_id, 0);
      chk("single_data_t2", bus1.rsp_data, 8);
      @(posedge clk); #1;
      chk("single_valid_t3", bus1.rsp_valid, 0);
      chk("single_busy_t3", bus1.busy, 0);
      chk("single_alu_a_hold", bus1.alu_a, 3);

      // Reserved op passes through; the ALU answers 0
      push1(1'b1, 4'd0);
      send1(1'b1, 4'd5, 4'd3, ALU_RSV);
      chk("rsv_alu_op", bus1.alu_op, 6);
      wait_idle1();

      // NOT and OR
      push1(1'b0, 4'd10);
      send1(1'b0, 4'd5, 4'd0, ALU_NOT);
      push1(1'b1, 4'd13);
      send1(1'b1, 4'd9, 4'd4, ALU_OR);
      wait_idle1();

      // Backpressure: 15+1 wraps to 0; req0 waits meanwhile (2&3=2)
      bus1.rsp_ready = 1'b0;
      push1(1'b1, 4'd0);
      push1(1'b0, 4'd2);
      send1(1'b1, 4'd15, 4'd1, ALU_ADD);
      fork
         send1(1'b0, 4'd2, 4'd3, ALU_AND);
      join_none
      begin
         bit seen = 1'b0;
         for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (bus1.rsp_valid) seen = 1'b1;
         end
         if (!seen) fail("bp_valid_timeout", "rsp_valid never rose");
      end
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", bus1.rsp_valid, 1);
         chk("bp_data", bus1.rsp_data, 0);
         chk("bp_id", bus1.rsp_id, 1);
         chk("bp_busy", bus1.busy, 1);
         chk("bp_req0_ready", bus1.req0_ready, 0);
      end
      @(posedge clk); #1;
      bus1.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_busy_handshake", bus1.busy, 1);
      @(posedge clk); #1;
      chk("bp_idle_after", bus1.busy, 0);
      chk("bp_valid_after", bus1.rsp_valid, 0);
      chk("bp_req0_ready_after", bus1.req0_ready, 1);
      wait_idle1();

      // Flag vectors: 7^7=0, 7&7=7
      push1(1'b0, 4'd0);
      send1(1'b0, 4'd7, 4'd7, ALU_XOR);
      push1(1'b0, 4'd7);
      send1(1'b0, 4'd7, 4'd7, ALU_AND);
      wait_idle1();

      // Mid-transaction reset on the ALU_LAT=4 instance
      send4(1'b0, 4'd1, 4'd2, ALU_ADD);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_alu_a", bus4.alu_a, 0);
      chk("arst_alu_b", bus4.alu_b, 0);
      chk("arst_alu_op", bus4.alu_op, 0);
      chk("arst_rsp_valid", bus4.rsp_valid, 0);
      chk("arst_rsp_data", bus4.rsp_data, 0);
      chk("arst_busy", bus4.busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("arst_no_rsp", bus4.rsp_valid, 0);
      push4(1'b1, 4'd7);
      send4(1'b1, 4'd4, 4'd3, ALU_ADD);
      repeat (3) @(posedge clk);
      #1;
      chk("lat4_valid_early", bus4.rsp_valid, 0);
      @(posedge clk); #1;
      chk("lat4_valid", bus4.rsp_valid, 1);
      chk("lat4_id", bus4.rsp_id, 1);
      chk("lat4_data", bus4.rsp_data, 7);
      repeat (2) @(posedge clk);
      #1;
      chk("lat4_idle", bus4.busy, 0);

      chk("q1_drained", q1.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencer and arbiter for the shared 4-bit ALU datapath (add/sub/not/and/or/xor/eq, 3-bit op).
- Two requesters issue operand/op transactions over valid/ready.
- The block grants one requester round-robin, drives the ALU operand and op inputs from registers, and waits a programmable settle time.
- It samples the ALU's 4-bit result (pre-7-segment) and returns it over a valid/ready response channel tagged with the requester ID.

Parameters:
W, 4, operand/result width; must match the ALU
ALU_LAT, 1, settle cycles between driving operands and sampling the result; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 transaction valid
req0_ready  out  1  requester 0 accepted this cycle
req0_a  in  W  requester 0 operand A
req0_b  in  W  requester 0 operand B
req0_op  in  3  requester 0 ALU op
req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
alu_a  out  W  registered operand A to ALU
alu_b  out  W  registered operand B to ALU
alu_op  out  3  registered op to ALU
alu_res  in  W  ALU 4-bit result, combinational from alu_a/alu_b/alu_op
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester that owns the response
rsp_data  out  W  sampled ALU result
busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, all outputs 0, last_grant=1 (so req0 wins first contention), settle counter 0.
- Reset mid-transaction drops the transaction; no response is produced.
- IDLE state:
  - Grant is combinational. One valid requester is granted.
  - If both are valid, grant goes to !last_grant.
  - reqN_ready=1 only for the granted requester, only in IDLE; ready is 0 in every other state.
  - On accept (valid&&ready) at cycle t: latch a/b/op into alu_a/alu_b/alu_op (visible t+1), latch the ID, set last_grant=ID, load cnt=ALU_LAT, go to ISSUE.
- ISSUE state:
  - cnt decrements each cycle.
  - In the cycle where cnt==1: rsp_data<=alu_res, rsp_id<=ID, rsp_valid<=1, go to DONE.
  - rsp_valid therefore first rises at t+1+ALU_LAT.
- DONE state:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1.
  - On that handshake edge, rsp_valid<=0 and state goes to IDLE; the next accept is possible in the following cycle.
  - Minimum spacing between accepts is ALU_LAT+2 cycles.
- alu_a/alu_b/alu_op hold their last values outside ISSUE (no glitching back to 0).
- The controller passes op 3'b110 (reserved) through; the ALU returns 0 for it.
- A requester dropping valid while not granted loses nothing. Its payload must be held stable while valid=1.
- A consumer holding rsp_ready=1 permanently sees exactly one valid cycle per transaction.
- Widths: no arithmetic here except the 4-bit cnt; alu_res is captured verbatim.

Optional Feature:
ALU_SEQ_FLAGS_EN
- Defined: adds output rsp_zero (1 bit), registered alongside rsp_data, =1 when alu_res==0 at the sample. Held with rsp_valid; reset 0.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - op constants: ALU_ADD=000, ALU_SUB=001, ALU_NOT=010, ALU_AND=011, ALU_OR=100, ALU_XOR=101, ALU_RSV=110, ALU_EQ=111;
  - state encoding S_IDLE/S_ISSUE/S_DONE (2 bits);
  - the default width W=4.
- Sub-module rr_arb2 is the 2-way round-robin arbiter. Inputs: valid[1:0], last_grant, en. Outputs: one-hot grant, grant_id. Purely combinational; last_grant is stored in alu_seq_ctrl.

Test Plan:
- Single request (ALU_LAT=1): reset, then req0 {a=3,b=5,op=000} with rsp_ready=1 -> accept at t; alu_a=3, alu_b=5 at t+1; rsp_valid=1, rsp_id=0, rsp_data=8 at t+2 for one cycle.
- Contention: req0 {9,4,001} and req1 {6,6,111} valid together, held -> req0 served first (rsp_data=5, id 0), then req1 (rsp_data=1, id 1); req1_ready stays 0 until req0's response handshake.
- Fairness: both requesters valid continuously for 6 transactions -> rsp_id sequence 0,1,0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises on {15,1,000} -> rsp_data=0 (wrap) and rsp_id held stable, both req_ready=0, busy=1; raise rsp_ready -> IDLE next cycle.
- Async reset: assert rst during ISSUE (ALU_LAT=4) between edges -> all outputs 0 immediately; no response after release; the next req1 is accepted normally.
- ALU_SEQ_FLAGS_EN: {7,7,101} -> rsp_data=0, rsp_zero=1; {7,7,011} -> rsp_data=7, rsp_zero=0.
